// File: rtl/result_uart_tx.sv
// result_uart_tx: 8N1 UART transmitter for the 32-bit Q16.16 solver result.
// Define RESULT_TX_HEX_EN to send 8 uppercase ASCII hex digits plus CR/LF instead of 4 raw bytes.
module result_uart_tx #(
   parameter int unsigned CLKS_PER_BIT = 868
) (
   input  logic        CLK,
   input  logic        CLR_N,
   input  logic        LD,
   input  logic [31:0] data_in,
   output logic        TX,
   output logic        BUSY,
   output logic        DONE
);

   localparam int unsigned CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

`ifdef RESULT_TX_HEX_EN
   localparam int unsigned BYTE_W = 4;
   localparam int unsigned NBYTES = 10;
`else
   localparam int unsigned BYTE_W = 2;
   localparam int unsigned NBYTES = 4;
`endif
   localparam logic [BYTE_W-1:0] BYTE_LAST = BYTE_W'(NBYTES - 1);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t            state;
   logic [31:0]       snap;
   logic [BYTE_W-1:0] byte_idx;
   logic [2:0]        bit_idx;
   logic [CNT_W-1:0]  baud_cnt;
   logic [7:0]        cur_byte;
   logic              bit_end;

   assign bit_end = (baud_cnt == CNT_LAST);

`ifdef RESULT_TX_HEX_EN
   logic [3:0] nib;

   always_comb begin
      nib = 4'(snap >> (5'd28 - {byte_idx[2:0], 2'b00}));
      if (byte_idx == 4'd8)
         cur_byte = 8'h0D;
      else if (byte_idx == 4'd9)
         cur_byte = 8'h0A;
      else if (nib < 4'd10)
         cur_byte = {4'h3, nib};
      else
         cur_byte = 8'h37 + {4'h0, nib};
   end
`else
   always_comb begin
      cur_byte = 8'(snap >> (5'd24 - {byte_idx, 3'b000}));
   end
`endif

   // TX is registered and set in the next-state branches so it lines up with the state it belongs to.
   always_ff @(posedge CLK or negedge CLR_N) begin
      if (!CLR_N) begin
         state    <= IDLE;
         snap     <= '0;
         byte_idx <= '0;
         bit_idx  <= '0;
         baud_cnt <= '0;
         TX       <= 1'b1;
         BUSY     <= 1'b0;
         DONE     <= 1'b0;
      end else begin
         DONE <= 1'b0;
         case (state)
            IDLE: begin
               if (LD) begin
                  snap     <= data_in;
                  byte_idx <= '0;
                  bit_idx  <= '0;
                  baud_cnt <= '0;
                  TX       <= 1'b0;
                  BUSY     <= 1'b1;
                  state    <= START;
               end
            end
            START: begin
               if (bit_end) begin
                  baud_cnt <= '0;
                  bit_idx  <= '0;
                  TX       <= cur_byte[0];
                  state    <= DATA;
               end else begin
                  baud_cnt <= baud_cnt + 1'b1;
               end
            end
            DATA: begin
               if (bit_end) begin
                  baud_cnt <= '0;
                  if (bit_idx == 3'd7) begin
                     TX    <= 1'b1;
                     state <= STOP;
                  end else begin
                     bit_idx <= bit_idx + 3'd1;
                     TX      <= cur_byte[bit_idx + 3'd1];
                  end
               end else begin
                  baud_cnt <= baud_cnt + 1'b1;
               end
            end
            STOP: begin
               if (bit_end) begin
                  baud_cnt <= '0;
                  if (byte_idx == BYTE_LAST) begin
                     byte_idx <= '0;
                     BUSY     <= 1'b0;
                     DONE     <= 1'b1;
                     state    <= IDLE;
                  end else begin
                     byte_idx <= byte_idx + 1'b1;
                     TX       <= 1'b0;
                     state    <= START;
                  end
               end else begin
                  baud_cnt <= baud_cnt + 1'b1;
               end
            end
            default: begin
               TX    <= 1'b1;
               BUSY  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_result_uart_tx.sv
// Testbench for result_uart_tx: random words checked against a byte/bit-level model of the UART stream.
module tb_result_uart_tx;

   localparam int CPB = 4;
`ifdef RESULT_TX_HEX_EN
   localparam int NB = 10;
`else
   localparam int NB = 4;
`endif
   localparam int FRAME = NB * 10 * CPB;

   logic        CLK = 1'b0;
   logic        CLR_N = 1'b0;
   logic        LD = 1'b0;
   logic [31:0] data_in = '0;
   logic        TX, BUSY, DONE;

   int tests_run = 0;
   int tests_failed = 0;

   logic [7:0] exp_b [NB];
   logic [7:0] got_b [NB];
   int         tx_err, busy_err, first_bad;
   logic [2:0] done_obs;

   result_uart_tx #(.CLKS_PER_BIT(CPB)) dut (
      .CLK(CLK), .CLR_N(CLR_N), .LD(LD), .data_in(data_in),
      .TX(TX), .BUSY(BUSY), .DONE(DONE)
   );

   always #5 CLK = ~CLK;

   // Expected character sequence for one result word.
   function automatic void model(input logic [31:0] w);
`ifdef RESULT_TX_HEX_EN
      int nib;
      for (int i = 0; i < 8; i++) begin
         nib = int'((w >> (4 * (7 - i))) & 32'hF);
         exp_b[i] = (nib < 10) ? 8'(48 + nib) : 8'(55 + nib);
      end
      exp_b[8] = 8'h0D;
      exp_b[9] = 8'h0A;
`else
      for (int i = 0; i < 4; i++) exp_b[i] = 8'(w >> (8 * (3 - i)));
`endif
   endfunction

   task automatic start_ld(input logic [31:0] w);
      @(negedge CLK);
      LD = 1'b1;
      data_in = w;
      @(negedge CLK);
      LD = 1'b0;
      data_in = $urandom;
   endtask

   // Walks one frame from its first start-bit cycle, recording deviations; ends in the DONE cycle.
   task automatic capture(input int inj_cycle, input logic [31:0] inj_word,
                          input bit chain, input logic [31:0] chain_word);
      int k, bidx, bpos;
      logic exp_tx;
      tx_err = 0; busy_err = 0; first_bad = -1;
      for (int i = 0; i < NB; i++) got_b[i] = 8'h00;
      for (int c = 1; c <= FRAME; c++) begin
         k = c - 1;
         bidx = k / (10 * CPB);
         bpos = (k % (10 * CPB)) / CPB;
         if (bpos == 0) exp_tx = 1'b0;
         else if (bpos == 9) exp_tx = 1'b1;
         else exp_tx = exp_b[bidx][bpos-1];
         if (TX !== exp_tx) begin
            tx_err++;
            if (first_bad < 0) first_bad = c;
         end
         if (BUSY !== 1'b1 || DONE !== 1'b0) busy_err++;
         if (bpos >= 1 && bpos <= 8 && (k % CPB) == CPB / 2) got_b[bidx][bpos-1] = TX;
         if (c == inj_cycle) begin
            LD = 1'b1;
            data_in = inj_word;
         end else if (c == inj_cycle + 1) begin
            LD = 1'b0;
            data_in = $urandom;
         end
         @(negedge CLK);
      end
      done_obs = {DONE, BUSY, TX};
      if (chain) begin
         LD = 1'b1;
         data_in = chain_word;
      end
   endtask

   task automatic test_reset();
      int bad = 0;
      CLR_N = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(negedge CLK);
         LD = i[0];
         data_in = $urandom;
         if (TX !== 1'b1 || BUSY !== 1'b0 || DONE !== 1'b0) bad++;
      end
      tests_run++;
      if (bad != 0) begin
         tests_failed++;
         $display("FAIL reset_hold: %0d bad cycles, required 0 (TX=%b BUSY=%b DONE=%b)", bad, TX, BUSY, DONE);
      end
      LD = 1'b0;
      CLR_N = 1'b1;
      bad = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge CLK);
         if (TX !== 1'b1 || BUSY !== 1'b0 || DONE !== 1'b0) bad++;
      end
      tests_run++;
      if (bad != 0) begin
         tests_failed++;
         $display("FAIL reset_release_idle: %0d bad cycles, required 0", bad);
      end
   endtask

   task automatic test_raw_send();
      logic [31:0] w = 32'h00038000;
`ifndef RESULT_TX_HEX_EN
      logic [7:0] lit [4] = '{8'h00, 8'h03, 8'h80, 8'h00};
`endif
      model(w);
      start_ld(w);
      capture(0, '0, 1'b0, '0);
      tests_run++;
      if (tx_err != 0) begin
         tests_failed++;
         $display("FAIL raw_tx_stream: %0d wrong cycles (first at %0d), required 0", tx_err, first_bad);
      end
      tests_run++;
      if (busy_err != 0) begin
         tests_failed++;
         $display("FAIL raw_busy: %0d cycles without BUSY=1/DONE=0, required 0", busy_err);
      end
`ifndef RESULT_TX_HEX_EN
      for (int i = 0; i < 4; i++) begin
         tests_run++;
         if (got_b[i] !== lit[i]) begin
            tests_failed++;
            $display("FAIL raw_byte%0d: got %h, required %h", i, got_b[i], lit[i]);
         end
      end
`endif
      tests_run++;
      if (done_obs !== 3'b101) begin
         tests_failed++;
         $display("FAIL raw_done_cycle: {DONE,BUSY,TX}=%b at cycle %0d, required 101", done_obs, FRAME + 1);
      end
      @(negedge CLK);
      tests_run++;
      if ({DONE, BUSY, TX} !== 3'b001) begin
         tests_failed++;
         $display("FAIL raw_after_done: {DONE,BUSY,TX}=%b, required 001", {DONE, BUSY, TX});
      end
   endtask

   task automatic test_busy_ignore();
      logic [31:0] w = $urandom;
      int bad = 0;
      model(w);
      start_ld(w);
      capture(20, 32'hFFFFFFFF, 1'b0, '0);
      tests_run++;
      if (tx_err != 0 || busy_err != 0) begin
         tests_failed++;
         $display("FAIL busy_stream: tx_err=%0d busy_err=%0d (first at %0d), required 0/0", tx_err, busy_err, first_bad);
      end
      tests_run++;
      if (done_obs !== 3'b101) begin
         tests_failed++;
         $display("FAIL busy_done: {DONE,BUSY,TX}=%b, required 101", done_obs);
      end
      for (int i = 0; i < 3 * 10 * CPB; i++) begin
         @(negedge CLK);
         if ({DONE, BUSY, TX} !== 3'b001) bad++;
      end
      tests_run++;
      if (bad != 0) begin
         tests_failed++;
         $display("FAIL busy_no_second_frame: %0d non-idle cycles, required 0", bad);
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] w;
      logic [31:0] nxt;
      int bad = 0;
      w = $urandom;
      model(w);
      start_ld(w);
      for (int r = 0; r < 3; r++) begin
         nxt = (r == 0) ? 32'h12345678 : $urandom;
         capture(0, '0, 1'b1, nxt);
         tests_run++;
         if (done_obs !== 3'b101) begin
            tests_failed++;
            $display("FAIL b2b_done%0d: {DONE,BUSY,TX}=%b, required 101", r, done_obs);
         end
         model(nxt);
         @(negedge CLK);
         LD = 1'b0;
         data_in = $urandom;
      end
      capture(0, '0, 1'b0, '0);
      tests_run++;
      if (tx_err != 0 || busy_err != 0) begin
         tests_failed++;
         $display("FAIL b2b_last_stream: tx_err=%0d busy_err=%0d (first at %0d), required 0/0", tx_err, busy_err, first_bad);
      end
      for (int i = 0; i < NB; i++)
         if (got_b[i] !== exp_b[i]) bad++;
      tests_run++;
      if (bad != 0 || done_obs !== 3'b101) begin
         tests_failed++;
         $display("FAIL b2b_last_bytes: %0d bad bytes, done=%b, required 0 and 101", bad, done_obs);
      end
      @(negedge CLK);
   endtask

   task automatic test_b2b_first();
      // The 0x12345678 frame immediately after a DONE cycle is checked byte by byte.
      logic [31:0] w = $urandom;
`ifndef RESULT_TX_HEX_EN
      logic [7:0] lit [4] = '{8'h12, 8'h34, 8'h56, 8'h78};
`endif
      model(w);
      start_ld(w);
      capture(0, '0, 1'b1, 32'h12345678);
      model(32'h12345678);
      @(negedge CLK);
      LD = 1'b0;
      data_in = $urandom;
      tests_run++;
      if (TX !== 1'b0 || BUSY !== 1'b1) begin
         tests_failed++;
         $display("FAIL b2b_start_bit: TX=%b BUSY=%b, required 0/1", TX, BUSY);
      end
      capture(0, '0, 1'b0, '0);
`ifndef RESULT_TX_HEX_EN
      for (int i = 0; i < 4; i++) begin
         tests_run++;
         if (got_b[i] !== lit[i]) begin
            tests_failed++;
            $display("FAIL b2b_byte%0d: got %h, required %h", i, got_b[i], lit[i]);
         end
      end
`endif
      tests_run++;
      if (tx_err != 0) begin
         tests_failed++;
         $display("FAIL b2b_stream: %0d wrong cycles (first at %0d), required 0", tx_err, first_bad);
      end
      @(negedge CLK);
   endtask

   task automatic test_mid_reset();
      logic [31:0] w = $urandom & 32'hFFFF00FF;
      int bad = 0;
      model(w);
      start_ld(w);
      repeat (90) @(negedge CLK);
      CLR_N = 1'b0;
      #1;
      tests_run++;
      if ({TX, BUSY, DONE} !== 3'b100) begin
         tests_failed++;
         $display("FAIL midreset_async: {TX,BUSY,DONE}=%b, required 100", {TX, BUSY, DONE});
      end
      repeat (2) @(negedge CLK);
      CLR_N = 1'b1;
      model(32'hA5A5A5A5);
      start_ld(32'hA5A5A5A5);
      capture(0, '0, 1'b0, '0);
      for (int i = 0; i < NB; i++)
         if (got_b[i] !== exp_b[i]) bad++;
      tests_run++;
      if (tx_err != 0 || busy_err != 0 || bad != 0) begin
         tests_failed++;
         $display("FAIL midreset_restart: tx_err=%0d busy_err=%0d bad_bytes=%0d, required 0/0/0", tx_err, busy_err, bad);
      end
      tests_run++;
      if (done_obs !== 3'b101) begin
         tests_failed++;
         $display("FAIL midreset_done: {DONE,BUSY,TX}=%b, required 101", done_obs);
      end
      @(negedge CLK);
   endtask

`ifdef RESULT_TX_HEX_EN
   task automatic test_hex();
      logic [7:0] lit [10] = '{8'h30, 8'h30, 8'h30, 8'h31, 8'h41, 8'h32, 8'h46, 8'h30, 8'h0D, 8'h0A};
      model(32'h0001A2F0);
      start_ld(32'h0001A2F0);
      capture(0, '0, 1'b0, '0);
      for (int i = 0; i < 10; i++) begin
         tests_run++;
         if (got_b[i] !== lit[i]) begin
            tests_failed++;
            $display("FAIL hex_char%0d: got %h, required %h", i, got_b[i], lit[i]);
         end
      end
      tests_run++;
      if (tx_err != 0 || done_obs !== 3'b101) begin
         tests_failed++;
         $display("FAIL hex_frame: tx_err=%0d done=%b at cycle %0d, required 0 and 101", tx_err, done_obs, FRAME + 1);
      end
      @(negedge CLK);
   endtask
`endif

   initial begin
      test_reset();
      test_raw_send();
      test_busy_ignore();
      test_b2b_first();
      test_back_to_back();
      test_mid_reset();
`ifdef RESULT_TX_HEX_EN
      test_hex();
`endif
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
